frida_spi_cfg: RTL
==================

FRIDA_SPI_CFG -- requirements
Module: frida_spi_cfg

Interface
REQ-001 Parameter CFG_BITS, default 1280: configuration frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on spi_sclk, spi_sdi, spi_cs_b.
REQ-003 clk  input  1  single block clock; oversamples SPI, frequency at least 4x spi_sclk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 spi_sclk  input  1  SPI clock from the pad receiver, asynchronous to clk.
REQ-006 spi_sdi  input  1  SPI serial data in (MOSI), MSB-first.
REQ-007 spi_cs_b  input  1  SPI chip select, active-low.
REQ-008 spi_sdo  output  1  SPI serial data out (MISO) to the pad driver.
REQ-009 cfg_q  output  CFG_BITS  committed configuration to the ADC array and comparator mux.
REQ-010 cfg_update  output  1  one-cycle pulse, high in the cycle cfg_q first shows new content.
REQ-011 frame_err  output  1  sticky flag: the last frame was not exactly CFG_BITS long.
REQ-012 busy  output  1  high while synchronized spi_cs_b is low.

Function
REQ-013 spi_sclk, spi_sdi and spi_cs_b SHALL each pass through SYNC_STAGES flops, then one edge-detect register.
REQ-014 Synchronized spi_cs_b falling edge SHALL clear bit counter cnt, clear frame_err, and load shift register sr with cfg_q.
REQ-015 Each synchronized spi_sclk rising edge with cs_b low SHALL shift sr left by one, insert the synchronized spi_sdi at bit 0, and increment cnt.
REQ-016 cnt SHALL be ceil(log2(CFG_BITS+2)) bits wide and saturate at CFG_BITS+1; there is no wrap-around.
REQ-017 spi_sdo SHALL equal sr[CFG_BITS-1] and SHALL update only on a synchronized spi_sclk falling edge; a frame therefore reads back the previous cfg_q MSB-first.
REQ-018 Synchronized spi_cs_b rising edge with cnt==CFG_BITS SHALL copy sr to cfg_q and assert cfg_update for exactly one clk cycle.
REQ-019 Synchronized spi_cs_b rising edge with cnt!=CFG_BITS, including cnt==0, SHALL leave cfg_q unchanged, assert no cfg_update, and set frame_err.
REQ-020 Latency: cfg_q and cfg_update SHALL change on the (SYNC_STAGES+2)th clk rising edge after spi_cs_b rises at the input.
REQ-021 Sclk edges while cs_b is high SHALL be ignored. A cs_b edge and an sclk edge detected in the same cycle SHALL give the cs_b edge priority.
REQ-022 State machine: IDLE (cs_b high) -> SHIFT on cs_b fall; SHIFT -> COMMIT on cs_b rise with a valid count, else SHIFT -> IDLE with frame_err set; COMMIT -> IDLE after one cycle.

Reset
REQ-023 While rst is high at a clk edge: cfg_q=0, sr=0, cnt=0, cfg_update=0, frame_err=0, busy=0, spi_sdo=0, state=IDLE, synchronizer flops preset to sclk=0, sdi=0, cs_b=1.
REQ-024 rst asserted mid-frame SHALL abort the frame with no commit. After release, the rest of that frame SHALL be ignored until a fresh cs_b falling edge.

Configuration
REQ-025 Macro FRIDA_SPI_READBACK_EN defined: spi_sdo behaves per REQ-017.
REQ-026 Macro FRIDA_SPI_READBACK_EN undefined: spi_sdo is constant 0, the sr load in REQ-014 is omitted, and sr is cleared on cs_b fall instead.

Structure
REQ-027 The shared package frida_pkg SHALL hold the CFG_BITS default (FRIDA_CFG_BITS=1280), the state enum {IDLE, SHIFT, COMMIT}, and the cfg_q field offsets (per-ADC 80-bit slices, mux select field).
REQ-028 There is one sub-module, frida_sync_edge: an N-stage synchronizer plus rise/fall detect, instantiated three times.

Verification
REQ-029 Reset, then a 1280-bit frame of 0xA5 repeated -> cfg_q=0xA5..A5, one cfg_update pulse at SYNC_STAGES+2 cycles after cs_b rises, frame_err=0.
REQ-030 A second frame of all-ones (readback enabled) -> spi_sdo emits the 0xA5 pattern MSB-first, and afterwards cfg_q is all-ones.
REQ-031 A frame of 1279 bits, then a frame of 1281 bits -> cfg_q unchanged, no cfg_update, frame_err=1 after each frame.
REQ-032 Toggle cs_b low then high with no sclk -> frame_err=1, cfg_q unchanged. Sclk pulses while cs_b is high -> no state change.
REQ-033 rst pulsed after 600 bits of a frame -> all outputs 0. The remaining 680 bits and the cs_b rise -> no commit, and cnt stays 0.
REQ-034 Built without FRIDA_SPI_READBACK_EN, a valid frame -> spi_sdo stays 0 throughout and cfg_q updates normally.

Source files
------------

// File: rtl/frida_pkg.sv
// Shared FRIDA definitions: configuration frame length, SPI config FSM states, cfg_q field map.
package frida_pkg;

  localparam int FRIDA_CFG_BITS = 1280;

  // cfg_q layout: 15 per-ADC 80-bit slices from bit 0 upward, then the comparator mux select
  localparam int ADC_CFG_BITS = 80;
  localparam int NUM_ADC      = 15;
  localparam int MUX_SEL_LSB  = NUM_ADC * ADC_CFG_BITS;
  localparam int MUX_SEL_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic int adc_cfg_lsb(input int adc);
    return adc * ADC_CFG_BITS;
  endfunction

endpackage

// File: rtl/frida_sync_edge.sv
// N-stage synchronizer for one async pad input, with rise/fall detect against a registered copy.
// Latency: STAGES cycles to lvl, edge pulses in the same cycle lvl changes.
// Backpressure: none, free-running.
module frida_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sync[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= sync[STAGES-1];
    end
  end

  assign lvl  = sync[STAGES-1];
  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

endmodule

// File: rtl/frida_spi_cfg.sv
// SPI slave loading a CFG_BITS configuration frame; commits only exact-length frames.
// Latency: cfg_q/cfg_update change SYNC_STAGES+2 clk edges after spi_cs_b rises; readback via FRIDA_SPI_READBACK_EN.
// Backpressure: none, SPI master paces the transfer; clk must run at least 4x spi_sclk.
module frida_spi_cfg
  import frida_pkg::*;
#(
  parameter int CFG_BITS    = FRIDA_CFG_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_sclk,
  input  logic                spi_sdi,
  input  logic                spi_cs_b,
  output logic                spi_sdo,
  output logic [CFG_BITS-1:0] cfg_q,
  output logic                cfg_update,
  output logic                frame_err,
  output logic                busy
);

  localparam int               CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic cs_lvl, cs_rise, cs_fall;

  frida_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi_sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  frida_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sdi (
    .clk(clk), .rst(rst), .din(spi_sdi), .lvl(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );
  frida_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(spi_cs_b), .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  state_t              state, state_nxt;
  logic [CFG_BITS-1:0] sr;
  logic [CNT_W-1:0]    cnt;
  logic [SYNC_STAGES:0] flush;
  logic                armed;
  logic                do_load, do_shift, do_commit, set_err;

  // After reset the preset synchronizer flushes to the pad value; a cs_b that was already
  // low would look like a fresh fall, so frames only start once cs_b has been seen high.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          do_load   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (cnt == CNT_FULL) begin
            state_nxt = COMMIT;
          end else begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (sclk_rise && !cs_fall) begin
          do_shift = 1'b1;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      sr         <= '0;
      cnt        <= '0;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      flush      <= '0;
      armed      <= 1'b0;
    end else begin
      flush      <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && cs_lvl) armed <= 1'b1;
      cfg_update <= do_commit;
      if (do_commit) cfg_q <= sr;
      if (do_load) begin
        cnt       <= '0;
        frame_err <= 1'b0;
`ifdef FRIDA_SPI_READBACK_EN
        sr        <= cfg_q;
`else
        sr        <= '0;
`endif
      end else if (do_shift) begin
        sr <= {sr[CFG_BITS-2:0], sdi_lvl};
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
      if (set_err) frame_err <= 1'b1;
    end
  end

  assign busy = ~cs_lvl;

`ifdef FRIDA_SPI_READBACK_EN
  logic sdo_q;
  logic unused_edges;

  // Master samples on sclk rise, so the next bit is presented on the preceding fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdo_q <= 1'b0;
    end else if (state == SHIFT && sclk_fall && !cs_rise && !cs_fall) begin
      sdo_q <= sr[CFG_BITS-1];
    end
  end

  assign spi_sdo      = sdo_q;
  assign unused_edges = &{1'b0, sclk_lvl, sdi_rise, sdi_fall};
`else
  logic unused_edges;

  assign spi_sdo      = 1'b0;
  assign unused_edges = &{1'b0, sclk_lvl, sclk_fall, sdi_rise, sdi_fall};
`endif

endmodule
